// File: rtl/param_rr_mux.sv
// param_rr_mux: N-channel valid/ready multiplexer with one registered output word.
// Arbitration is round-robin (mode=0) or fixed priority, lowest index first (mode=1).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode                  0 = round-robin, 1 = fixed priority
//   in_data/in_valid      packed channel data (channel i at [i*WIDTH +: WIDTH]) and valids
//   in_ready              per-channel ready; only the granted channel sees 1
//   out_data/out_sel      registered selected word and the index of its source channel
//   out_valid/out_ready   output handshake
//   xfer_cnt              accepted input transfers, modulo 256
module param_rr_mux #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                xfer_cnt
);

  // One extra bit so start + offset cannot overflow before the wrap subtraction.
  localparam int unsigned IW = SELW + 1;

  logic [WIDTH-1:0] ch_data [CHANNELS];
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  start;
  logic [IW-1:0]    cand;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_found;
  logic             load_en;
  logic             xfer_en;

  // Unpack channel data for indexed selection.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Grant search: first valid channel upward from start, wrapping at CHANNELS.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    cand      = '0;
    start     = mode ? '0 : ptr;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      cand = IW'(start) + IW'(k);
      if (cand >= IW'(CHANNELS)) cand = cand - IW'(CHANNELS);
      if (!gnt_found && in_valid[cand[SELW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[SELW-1:0];
      end
    end
  end

  assign load_en = !out_valid || out_ready;
  // rst_n gates the grant so ready stays low throughout reset.
  assign xfer_en = load_en && gnt_found && rst_n;
  assign in_ready = xfer_en ? (CHANNELS'(1) << gnt_idx) : '0;

  // Output word, pointer and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
      xfer_cnt  <= '0;
    end else if (xfer_en) begin
      out_data  <= ch_data[gnt_idx];
      out_sel   <= gnt_idx;
      out_valid <= 1'b1;
      xfer_cnt  <= xfer_cnt + 8'd1;
      if (!mode) begin
        ptr <= (gnt_idx == SELW'(CHANNELS - 1)) ? '0 : gnt_idx + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_rr_mux.sv
// Directed bench for param_rr_mux: a 4-channel instance and a 3-channel instance
// (non-power-of-two wrap), sharing clock and reset.
module tb_param_rr_mux;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  xfer_cnt;

  logic        mode3;
  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [3:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3;
  logic        out_ready3;
  logic [7:0]  xfer_cnt3;

  int tests = 0;
  int fails = 0;

  param_rr_mux #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  param_rr_mux #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3), .xfer_cnt(xfer_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rr_sel[5] = '{0, 1, 2, 3, 0};
    int w3_sel[4] = '{0, 1, 2, 0};
    logic [3:0] w3_data[3] = '{4'h1, 4'h2, 4'h4};

    rst_n = 1'b0; mode = 1'b0; in_valid = 4'hF; in_data = 16'h8421; out_ready = 1'b1;
    mode3 = 1'b0; in_valid3 = 3'b000; in_data3 = 12'h421; out_ready3 = 1'b1;

    // Reset values without any clock edge.
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_sel", 32'(out_sel), 32'd0);
    check("rst_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    step();
    check("rst_hold_ready", 32'(in_ready), 32'd0);
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'b0001);

    // Round-robin over four always-valid channels.
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_sel", 32'(out_sel), 32'(rr_sel[i]));
      check("rr_data", 32'(out_data), 32'(1 << rr_sel[i]));
      check("rr_valid", 32'(out_valid), 32'd1);
    end
    check("rr_cnt", 32'(xfer_cnt), 32'd5);
    check("rr_next_ready", 32'(in_ready), 32'b0010);

    // Fixed priority with channels 1 and 3 valid: channel 1 always wins.
    mode = 1'b1; in_valid = 4'b1010;
    #1;
    check("fp_ready_now", 32'(in_ready), 32'b0010);
    for (int i = 0; i < 3; i++) begin
      step();
      check("fp_sel", 32'(out_sel), 32'd1);
      check("fp_data", 32'(out_data), 32'h2);
      check("fp_ready", 32'(in_ready), 32'b0010);
    end
    check("fp_cnt", 32'(xfer_cnt), 32'd8);

    // Backpressure: word held, no grants.
    out_ready = 1'b0;
    #1;
    check("bp_ready_now", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_data", 32'(out_data), 32'h2);
      check("bp_sel", 32'(out_sel), 32'd1);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(in_ready), 32'd0);
    end
    check("bp_cnt", 32'(xfer_cnt), 32'd8);

    // Release with mode switched back to round-robin in the same cycle; ptr held at 1.
    mode = 1'b0; in_valid = 4'b1100; out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0100);
    step();
    check("bp_release_sel", 32'(out_sel), 32'd2);
    check("bp_release_data", 32'(out_data), 32'h4);
    check("bp_release_cnt", 32'(xfer_cnt), 32'd9);

    // Drain: output accepted, nothing new offered.
    in_valid = 4'b0000;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data", 32'(out_data), 32'h4);
    check("drain_sel", 32'(out_sel), 32'd2);
    check("drain_ready", 32'(in_ready), 32'd0);

    // Load a word from channel 3 (ptr=3), then reset mid-stream with the word held.
    in_valid = 4'hF;
    step();
    check("pre_rst_sel", 32'(out_sel), 32'd3);
    check("pre_rst_data", 32'(out_data), 32'h8);
    check("pre_rst_cnt", 32'(xfer_cnt), 32'd10);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_sel", 32'(out_sel), 32'd0);
    check("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'b0001);
    step();
    check("post_rst_sel", 32'(out_sel), 32'd0);
    check("post_rst_cnt", 32'(xfer_cnt), 32'd1);

    // Counter wrap: 256 transfers since reset.
    repeat (254) step();
    check("cnt_255", 32'(xfer_cnt), 32'd255);
    step();
    check("cnt_wrap", 32'(xfer_cnt), 32'd0);
    check("cnt_wrap_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;

    // Three-channel round-robin wrap.
    in_valid3 = 3'b100;
    #1;
    check("w3_first_ready", 32'(in_ready3), 32'b100);
    step();
    check("w3_first_sel", 32'(out_sel3), 32'd2);
    check("w3_first_data", 32'(out_data3), 32'h4);
    in_valid3 = 3'b111;
    #1;
    check("w3_wrap_ready", 32'(in_ready3), 32'b001);
    for (int i = 0; i < 4; i++) begin
      step();
      check("w3_sel", 32'(out_sel3), 32'(w3_sel[i]));
      check("w3_data", 32'(out_data3), 32'(w3_data[w3_sel[i]]));
    end
    check("w3_cnt", 32'(xfer_cnt3), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_rr_mux.md
PARAM_RR_MUX -- requirements
Module: param_rr_mux

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data width of every channel and of the output.
REQ-002 Parameter CHANNELS, default 4, range 2..16, SHALL set the number of input channels.
REQ-003 Parameter SELW, default $clog2(CHANNELS), SHALL set the width of the channel index.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 mode  input  1  SHALL select arbitration: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 in_data  input  CHANNELS*WIDTH  SHALL carry channel i data in bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  CHANNELS  SHALL carry one valid bit per channel.
REQ-009 in_ready  output  CHANNELS  SHALL carry one ready bit per channel.
REQ-010 out_data  output  WIDTH  SHALL carry the registered selected data.
REQ-011 out_sel  output  SELW  SHALL carry the index of the channel that supplied out_data.
REQ-012 out_valid  output  1  SHALL flag that out_data/out_sel hold a word.
REQ-013 out_ready  input  1  SHALL flag that the consumer accepts the output word.
REQ-014 xfer_cnt  output  8  SHALL count accepted input transfers, wrapping 255 -> 0.

Function
REQ-015 An input transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-016 load_en SHALL be (!out_valid || out_ready), evaluated combinationally.
REQ-017 Exactly one channel SHALL be granted when load_en is 1 and any in_valid is 1; no channel SHALL be granted otherwise.
REQ-018 in_ready[i] SHALL be 1 only for the granted channel; in_ready SHALL NOT depend combinationally on in_data.
REQ-019 Round-robin mode: grant SHALL go to the first valid channel searching upward from pointer ptr, wrapping CHANNELS-1 -> 0.
REQ-020 Round-robin mode: after a transfer on channel g, ptr SHALL become g+1, wrapping to 0 when g = CHANNELS-1 (also for non-power-of-two CHANNELS).
REQ-021 Fixed-priority mode: grant SHALL go to the lowest-index valid channel; ptr SHALL hold its value.
REQ-022 A mode change SHALL affect the grant in the same cycle it is applied; no transfer SHALL be lost or duplicated.
REQ-023 On an input transfer, out_data, out_sel and out_valid=1 SHALL be registered at that edge (latency 1 cycle).
REQ-024 On an output transfer with no input transfer, out_valid SHALL clear; out_data and out_sel SHALL hold.
REQ-025 Simultaneous output and input transfers SHALL replace the output word, sustaining 1 word/cycle.
REQ-026 While out_valid=1 and out_ready=0, all in_ready SHALL be 0 and out_data, out_sel, out_valid SHALL hold stable.
REQ-027 xfer_cnt SHALL increment by 1 per input transfer, modulo 256.

Reset
REQ-028 While rst_n=0, out_valid, out_data, out_sel, ptr and xfer_cnt SHALL be 0 immediately, independent of clk.
REQ-029 While rst_n=0, all in_ready SHALL be 0.
REQ-030 Reset asserted mid-stream SHALL discard the held output word; after release the first grant SHALL start from channel 0.

Verification (WIDTH=4, CHANNELS=4)
REQ-031 Reset: rst_n=0 mid-transfer, no clk edge -> out_valid=0, out_data=0000, out_sel=0, xfer_cnt=0, in_ready=0000 at once.
REQ-032 Round-robin fairness: mode=0, all valid, data ch0..3 = 0001/0010/0100/1000, out_ready=1 -> out_sel sequence 0,1,2,3,0 with matching data, one word/cycle.
REQ-033 Fixed priority: mode=1, in_valid=1010, out_ready=1 -> out_sel stays 1 every cycle; ch3 never granted.
REQ-034 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0000, out_data stable; raise out_ready -> next word loads the same cycle.
REQ-035 Wrap: CHANNELS=3, mode=0, in_valid=100 then 111 -> grants 2, then 0, 1, 2.
REQ-036 Counter wrap: 256 consecutive transfers from reset -> xfer_cnt reads 255 then 0.
